column_compressor_15x15: RTL and testbench

- Pipelined column compressor (Dadda/Wallace style) for a 15x15 unsigned multiplier.
- Takes 29 bit-columns of partial products with heights 1,2,…,15,…,2,1, where every bit of column i has weight 2^i.
- Produces their 31-bit arithmetic sum, one output bit per port.
- Sits between the partial-product generator (or a register stage) and the multiplier result bus.

---
 rtl/column_compressor_15x15.sv | 176 +++++++++++++++++
 tb/tb_column_compressor_15x15.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/column_compressor_15x15.sv
// Two-stage column compressor for a 15x15 unsigned multiplier.
// A carry-save tree reduces 29 partial-product columns to two rows, then a final adder forms the 31-bit sum.
module column_compressor_15x15 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:0]  src0,
  input  logic [1:0]  src1,
  input  logic [2:0]  src2,
  input  logic [3:0]  src3,
  input  logic [4:0]  src4,
  input  logic [5:0]  src5,
  input  logic [6:0]  src6,
  input  logic [7:0]  src7,
  input  logic [8:0]  src8,
  input  logic [9:0]  src9,
  input  logic [10:0] src10,
  input  logic [11:0] src11,
  input  logic [12:0] src12,
  input  logic [13:0] src13,
  input  logic [14:0] src14,
  input  logic [13:0] src15,
  input  logic [12:0] src16,
  input  logic [11:0] src17,
  input  logic [10:0] src18,
  input  logic [9:0]  src19,
  input  logic [8:0]  src20,
  input  logic [7:0]  src21,
  input  logic [6:0]  src22,
  input  logic [5:0]  src23,
  input  logic [4:0]  src24,
  input  logic [3:0]  src25,
  input  logic [2:0]  src26,
  input  logic [1:0]  src27,
  input  logic [0:0]  src28,
  output logic        dst0,
  output logic        dst1,
  output logic        dst2,
  output logic        dst3,
  output logic        dst4,
  output logic        dst5,
  output logic        dst6,
  output logic        dst7,
  output logic        dst8,
  output logic        dst9,
  output logic        dst10,
  output logic        dst11,
  output logic        dst12,
  output logic        dst13,
  output logic        dst14,
  output logic        dst15,
  output logic        dst16,
  output logic        dst17,
  output logic        dst18,
  output logic        dst19,
  output logic        dst20,
  output logic        dst21,
  output logic        dst22,
  output logic        dst23,
  output logic        dst24,
  output logic        dst25,
  output logic        dst26,
  output logic        dst27,
  output logic        dst28,
  output logic        dst29,
  output logic        dst30
);

  localparam int COLS   = 29;
  localparam int ROWS   = 15;
  localparam int SUM_W  = 31;
  localparam int LEVELS = 6;   // 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2 rows

  typedef logic [SUM_W-1:0] row_t;

  logic [ROWS-1:0] col [COLS];
  row_t sum_row, carry_row;
  row_t sum_row_p1, carry_row_p1;
  row_t sum_p2;

  function automatic row_t fa_sum(input row_t a, input row_t b, input row_t c);
    return a ^ b ^ c;
  endfunction

  // Carry bits move one column up; the total never reaches 2^31, so bit 30's carry is always 0.
  function automatic row_t fa_carry(input row_t a, input row_t b, input row_t c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  assign col[0]  = ROWS'(src0);
  assign col[1]  = ROWS'(src1);
  assign col[2]  = ROWS'(src2);
  assign col[3]  = ROWS'(src3);
  assign col[4]  = ROWS'(src4);
  assign col[5]  = ROWS'(src5);
  assign col[6]  = ROWS'(src6);
  assign col[7]  = ROWS'(src7);
  assign col[8]  = ROWS'(src8);
  assign col[9]  = ROWS'(src9);
  assign col[10] = ROWS'(src10);
  assign col[11] = ROWS'(src11);
  assign col[12] = ROWS'(src12);
  assign col[13] = ROWS'(src13);
  assign col[14] = ROWS'(src14);
  assign col[15] = ROWS'(src15);
  assign col[16] = ROWS'(src16);
  assign col[17] = ROWS'(src17);
  assign col[18] = ROWS'(src18);
  assign col[19] = ROWS'(src19);
  assign col[20] = ROWS'(src20);
  assign col[21] = ROWS'(src21);
  assign col[22] = ROWS'(src22);
  assign col[23] = ROWS'(src23);
  assign col[24] = ROWS'(src24);
  assign col[25] = ROWS'(src25);
  assign col[26] = ROWS'(src26);
  assign col[27] = ROWS'(src27);
  assign col[28] = ROWS'(src28);

  // ---- Stage 1: carry-save reduction of 15 rows down to 2 ----
  always_comb begin : reduce
    row_t rows [ROWS];
    row_t nxt  [ROWS];
    int   n;
    int   m;
    for (int r = 0; r < ROWS; r++) begin
      rows[r] = '0;
      nxt[r]  = '0;
      for (int c = 0; c < COLS; c++) rows[r][c] = col[c][r];
    end
    n = ROWS;
    for (int lv = 0; lv < LEVELS; lv++) begin
      for (int r = 0; r < ROWS; r++) nxt[r] = '0;
      m = 0;
      for (int g = 0; g < ROWS / 3; g++) begin
        if (3 * g + 2 < n) begin
          nxt[m]     = fa_sum(rows[3*g], rows[3*g+1], rows[3*g+2]);
          nxt[m + 1] = fa_carry(rows[3*g], rows[3*g+1], rows[3*g+2]);
          m = m + 2;
        end
      end
      // Rows left over after grouping by three pass through to the next level untouched.
      for (int r = 0; r < ROWS; r++) begin
        if (r >= n - (n % 3) && r < n) begin
          nxt[m] = rows[r];
          m = m + 1;
        end
      end
      rows = nxt;
      n    = m;
    end
    sum_row   = rows[0];
    carry_row = rows[1];
  end

  // ---- P1: two-row register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_row_p1   <= '0;
      carry_row_p1 <= '0;
    end else begin
      sum_row_p1   <= sum_row;
      carry_row_p1 <= carry_row;
    end
  end

  // ---- Stage 2 / P2: carry-propagate add into the output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_p2 <= '0;
    else        sum_p2 <= sum_row_p1 + carry_row_p1;
  end

  assign {dst30, dst29, dst28, dst27, dst26, dst25, dst24, dst23, dst22, dst21, dst20,
          dst19, dst18, dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10,
          dst9, dst8, dst7, dst6, dst5, dst4, dst3, dst2, dst1, dst0} = sum_p2;

endmodule

// File: tb/tb_column_compressor_15x15.sv
// Bench for column_compressor_15x15: directed literal cases plus random columns
// checked every cycle against a two-cycle-delayed weighted-popcount model.
module tb_column_compressor_15x15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [14:0] cols [29];
  logic [30:0] dst_w;
  logic [30:0] m1, m2;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  column_compressor_15x15 dut (
    .clk(clk), .rst_n(rst_n),
    .src0(cols[0][0:0]),   .src1(cols[1][1:0]),   .src2(cols[2][2:0]),
    .src3(cols[3][3:0]),   .src4(cols[4][4:0]),   .src5(cols[5][5:0]),
    .src6(cols[6][6:0]),   .src7(cols[7][7:0]),   .src8(cols[8][8:0]),
    .src9(cols[9][9:0]),   .src10(cols[10][10:0]), .src11(cols[11][11:0]),
    .src12(cols[12][12:0]), .src13(cols[13][13:0]), .src14(cols[14][14:0]),
    .src15(cols[15][13:0]), .src16(cols[16][12:0]), .src17(cols[17][11:0]),
    .src18(cols[18][10:0]), .src19(cols[19][9:0]),  .src20(cols[20][8:0]),
    .src21(cols[21][7:0]),  .src22(cols[22][6:0]),  .src23(cols[23][5:0]),
    .src24(cols[24][4:0]),  .src25(cols[25][3:0]),  .src26(cols[26][2:0]),
    .src27(cols[27][1:0]),  .src28(cols[28][0:0]),
    .dst0(dst_w[0]),   .dst1(dst_w[1]),   .dst2(dst_w[2]),   .dst3(dst_w[3]),
    .dst4(dst_w[4]),   .dst5(dst_w[5]),   .dst6(dst_w[6]),   .dst7(dst_w[7]),
    .dst8(dst_w[8]),   .dst9(dst_w[9]),   .dst10(dst_w[10]), .dst11(dst_w[11]),
    .dst12(dst_w[12]), .dst13(dst_w[13]), .dst14(dst_w[14]), .dst15(dst_w[15]),
    .dst16(dst_w[16]), .dst17(dst_w[17]), .dst18(dst_w[18]), .dst19(dst_w[19]),
    .dst20(dst_w[20]), .dst21(dst_w[21]), .dst22(dst_w[22]), .dst23(dst_w[23]),
    .dst24(dst_w[24]), .dst25(dst_w[25]), .dst26(dst_w[26]), .dst27(dst_w[27]),
    .dst28(dst_w[28]), .dst29(dst_w[29]), .dst30(dst_w[30])
  );

  function automatic int hgt(input int i);
    return (i < 15) ? i + 1 : 29 - i;
  endfunction

  function automatic logic [14:0] col_mask(input int i);
    return 15'h7FFF >> (15 - hgt(i));
  endfunction

  // S = sum over columns of popcount(column) * 2^column
  function automatic logic [30:0] ref_sum();
    logic [30:0] s;
    s = '0;
    for (int i = 0; i < 29; i++)
      for (int k = 0; k < hgt(i); k++)
        if (cols[i][k]) s = s + (31'd1 << i);
    return s;
  endfunction

  task automatic check(input string nm, input logic [30:0] act, input logic [30:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_cols();
    for (int i = 0; i < 29; i++) cols[i] = '0;
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 29; i++) cols[i] = col_mask(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 29; i++) cols[i] = 15'($urandom) & col_mask(i);
  endtask

  // Partial products a[j]&b[l] land in column j+l, packed from bit 0 upward.
  task automatic set_mult(input logic [14:0] a, input logic [14:0] b);
    int l, k;
    clear_cols();
    for (int i = 0; i < 29; i++)
      for (int j = 0; j < 15; j++) begin
        l = i - j;
        if (l >= 0 && l < 15) begin
          k = j - ((i > 14) ? i - 14 : 0);
          cols[i][k] = a[j] & b[l];
        end
      end
  endtask

  // Entered at a falling edge with inputs just applied; result is visible after two rising edges.
  task automatic directed(input string nm, input logic [30:0] exp);
    check({nm, "_model"}, ref_sum(), exp);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check(nm, dst_w, exp);
  endtask

  // Reference pipeline: formula result delayed by two edges, flushed by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= ref_sum();
      m2 <= m1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("pipe", dst_w, m2);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] a, b;
    clear_cols();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    fill_ones();
    repeat (3) @(negedge clk);
    check("rst_hold", dst_w, 31'h0);

    rst_n = 1'b1;
    directed("rst_release", 31'h3FFF0001);

    #2 rst_n = 1'b0;
    #1 check("async_rst", dst_w, 31'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_first", dst_w, 31'h0);
    @(posedge clk);
    #1 check("post_rst_second", dst_w, 31'h3FFF0001);
    @(negedge clk);

    clear_cols(); cols[28][0] = 1'b1;
    directed("src28_bit0", 31'h1000_0000);
    clear_cols(); cols[0][0] = 1'b1;
    directed("src0_bit0", 31'h1);
    clear_cols(); cols[14] = 15'h7FFF;
    directed("src14_ones", 31'h3C000);
    clear_cols(); cols[7] = 15'h0004;
    directed("src7_one_bit", 31'h80);
    clear_cols(); cols[7] = 15'h00FF;
    directed("src7_ones", 31'h400);

    set_mult(15'd12345, 15'd6789);
    directed("mult_12345_6789", 31'd83810205);
    set_mult(15'd32767, 15'd32767);
    directed("mult_max", 31'h3FFF0001);
    set_mult(15'd0, 15'($urandom));
    directed("mult_a0", 31'h0);
    set_mult(15'($urandom), 15'd0);
    directed("mult_b0", 31'h0);

    repeat (1000) begin
      @(negedge clk);
      fill_random();
    end

    repeat (20) begin
      @(negedge clk);
      a = 15'($urandom);
      b = 15'($urandom);
      set_mult(a, b);
      directed("mult_rand", 31'(a) * 31'(b));
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
